// File: rtl/spi_master_ctrl.sv
// Memory-mapped SPI master, mode 0, MSB first, 1..32-bit transfers, with busy/done/irq status.
// Define SPI_RX_EN to build the MISO receive path; otherwise DATA reads return zero.
module spi_master_ctrl #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] DIV_RST = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        mem_write,
  input  logic [1:0]  addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  input  logic        spi_miso,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, START, SCK_HI, SCK_LO, FINISH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] div_r, xfer_div, cont;
  logic [4:0]       len_r;
  logic             ie_r, done_r, ovr_r;
  logic [31:0]      tx_shift, rx_data;
  logic [5:0]       bit_count, n_bits;
  logic             wr_en, data_wr, status_wr, ctrl_wr;
  logic             start_xfer, phase_end, set_done;

  assign wr_en      = sel & mem_write;
  assign data_wr    = wr_en & (addr == 2'd0);
  assign status_wr  = wr_en & (addr == 2'd1);
  assign ctrl_wr    = wr_en & (addr == 2'd2);
  assign busy       = (state != IDLE);
  assign start_xfer = data_wr & ~busy;
  assign phase_end  = (cont == xfer_div);
  assign set_done   = (state == FINISH) & phase_end;
  assign n_bits     = (len_r == 5'd0) ? 6'd32 : {1'b0, len_r};
  assign spi_mosi   = busy & tx_shift[31];
  assign irq        = done_r & ie_r;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    spi_cs_n  = 1'b0;
    spi_clk   = 1'b0;
    case (state)
      IDLE: begin
        spi_cs_n = 1'b1;
        if (start_xfer) state_nxt = START;
      end
      START:  if (phase_end) state_nxt = SCK_HI;
      SCK_HI: begin
        spi_clk = 1'b1;
        if (phase_end) state_nxt = (bit_count == 6'd1) ? FINISH : SCK_LO;
      end
      SCK_LO: if (phase_end) state_nxt = SCK_HI;
      FINISH: if (phase_end) state_nxt = IDLE;
      default: begin
        spi_cs_n  = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Divider, shifter and bit counter; the divider is frozen for the whole transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cont      <= '0;
      xfer_div  <= '0;
      tx_shift  <= '0;
      bit_count <= '0;
    end else begin
      if (state == IDLE || phase_end) cont <= '0;
      else                            cont <= cont + CNT_ONE;
      if (start_xfer) begin
        xfer_div  <= div_r;
        tx_shift  <= write_data << (6'd32 - n_bits);
        bit_count <= n_bits;
      end else if (state == SCK_HI && phase_end) begin
        bit_count <= bit_count - 6'd1;
        if (state_nxt == SCK_LO) tx_shift <= {tx_shift[30:0], 1'b0};
      end
    end
  end

  // Config and sticky status; a done/ovr set beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r  <= DIV_RST;
      len_r  <= 5'd8;
      ie_r   <= 1'b0;
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      if (ctrl_wr && !busy) begin
        div_r <= write_data[CNT_W-1:0];
        len_r <= write_data[12:8];
        ie_r  <= write_data[16];
      end
      if (set_done)                          done_r <= 1'b1;
      else if (status_wr && write_data[1])   done_r <= 1'b0;
      if (data_wr && busy)                   ovr_r  <= 1'b1;
      else if (status_wr && write_data[2])   ovr_r  <= 1'b0;
    end
  end

`ifdef SPI_RX_EN
  logic [31:0] rx_shift;

  // MISO is captured on the edge that enters SCK_HI; the result is published at FINISH exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (start_xfer)
        rx_shift <= '0;
      else if (state_nxt == SCK_HI && state != SCK_HI)
        rx_shift <= {rx_shift[30:0], spi_miso};
      if (set_done) rx_data <= rx_shift;
    end
  end
`else
  logic miso_unused;
  assign miso_unused = spi_miso;
  assign rx_data     = '0;
`endif

  always_comb begin
    read_data = '0;
    if (sel) begin
      case (addr)
        2'd0: read_data = rx_data;
        2'd1: read_data = {29'd0, ovr_r, done_r, busy};
        2'd2: begin
          read_data[CNT_W-1:0] = div_r;
          read_data[12:8]      = len_r;
          read_data[16]        = ie_r;
        end
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a per-cycle waveform model built from the transfer rules,
// directed scenarios with literal expectations, then randomized transfers.
module tb_spi_master_ctrl;

  logic        clk = 1'b0;
  logic        rst, sel, mem_write;
  logic [1:0]  addr;
  logic [31:0] write_data, read_data;
  logic        spi_clk, spi_mosi, spi_cs_n, spi_miso, busy, irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign spi_miso = spi_mosi;

  spi_master_ctrl dut (
    .clk(clk), .rst(rst), .sel(sel), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .read_data(read_data), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .busy(busy), .irq(irq)
  );

  typedef struct {
    bit cs_n;
    bit sck;
    bit mosi;
    bit mv;
    bit busy;
    bit last;
  } ent_t;

  ent_t        q[$];
  ent_t        cur_e;
  bit          chk_en = 1'b0;
  logic [7:0]  m_div;
  logic [4:0]  m_len;
  bit          m_ie, m_done, m_ovr;
  logic [31:0] m_rx, rx_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t idle_ent();
    return '{cs_n: 1'b1, sck: 1'b0, mosi: 1'b0, mv: 1'b0, busy: 1'b0, last: 1'b0};
  endfunction

  function automatic logic [31:0] mask_n(input logic [31:0] d, input int n);
    return (n == 32) ? d : (d & ((32'd1 << n) - 32'd1));
  endfunction

  // Expand one transfer into its cycle-by-cycle line levels.
  function automatic void push_xfer(input logic [31:0] d);
    int n  = (m_len == 5'd0) ? 32 : int'(m_len);
    int dv = int'(m_div);
    for (int c = 0; c <= dv; c++)
      q.push_back('{cs_n: 1'b0, sck: 1'b0, mosi: d[n-1], mv: 1'b1, busy: 1'b1, last: 1'b0});
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c <= dv; c++)
        q.push_back('{cs_n: 1'b0, sck: 1'b1, mosi: d[n-1-i], mv: 1'b1, busy: 1'b1, last: 1'b0});
      if (i < n - 1)
        for (int c = 0; c <= dv; c++)
          q.push_back('{cs_n: 1'b0, sck: 1'b0, mosi: d[n-2-i], mv: 1'b1, busy: 1'b1, last: 1'b0});
    end
    for (int c = 0; c <= dv; c++)
      q.push_back('{cs_n: 1'b0, sck: 1'b0, mosi: 1'b0, mv: 1'b0, busy: 1'b1, last: (c == dv)});
`ifdef SPI_RX_EN
    rx_pending = mask_n(d, n);
`else
    rx_pending = '0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_rx;
      2'd1:    return {29'd0, m_ovr, m_done, (q.size() > 0)};
      2'd2:    return {15'd0, m_ie, 3'd0, m_len, m_div};
      default: return 32'd0;
    endcase
  endfunction

  // Register-level model, advanced on every clock edge from the bus inputs.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur_e  = idle_ent();
      m_div  = 8'd4;
      m_len  = 5'd8;
      m_ie   = 1'b0;
      m_done = 1'b0;
      m_ovr  = 1'b0;
      m_rx   = '0;
    end else begin
      if (cur_e.last) begin
        m_done = 1'b1;
        m_rx   = rx_pending;
      end
      if (sel && mem_write) begin
        case (addr)
          2'd0: if (cur_e.busy) m_ovr = 1'b1; else push_xfer(write_data);
          2'd1: begin
            if (write_data[1] && !cur_e.last) m_done = 1'b0;
            if (write_data[2]) m_ovr = 1'b0;
          end
          2'd2: if (!cur_e.busy) begin
            m_div = write_data[7:0];
            m_len = write_data[12:8];
            m_ie  = write_data[16];
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (chk_en) begin
      if (q.size() > 0) e = q.pop_front();
      else              e = idle_ent();
      cur_e = e;
      check("cs_n", spi_cs_n, e.cs_n);
      check("sck", spi_clk, e.sck);
      check("busy", busy, e.busy);
      check("irq", irq, m_done & m_ie);
      if (e.mv) check("mosi", spi_mosi, e.mosi);
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; mem_write = 1'b1; addr = a; write_data = d;
    @(posedge clk); #1;
    sel = 1'b0; mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1; mem_write = 1'b0; addr = a;
    #2;
    v = read_data;
    check($sformatf("read_addr%0d", a), v, model_read(a));
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  // Watch a transfer until busy falls: busy cycles, SCK rises and MOSI at each rise.
  task automatic run_xfer(input int budget, output int bc, output int rs,
                          output logic [31:0] bits, output logic first_cs_n);
    logic prev = 1'b0;
    bc = 0; rs = 0; bits = '0; first_cs_n = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i == 0) first_cs_n = spi_cs_n;
      if (spi_clk && !prev) begin
        rs++;
        bits = {bits[30:0], spi_mosi};
      end
      prev = spi_clk;
      if (busy) bc++;
      else if (bc > 0) break;
    end
    check("xfer_end_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v, bits, d, c;
    logic        fcs;
    int          bc, rs, n, dv;
    bit          ovr_try;

    rst = 1'b1; sel = 1'b0; mem_write = 1'b0; addr = 2'd0; write_data = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;

    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_sck", spi_clk, 1'b0);
    bus_read(2'd1, v); check("rst_status", v, 32'h0);
    bus_read(2'd2, v); check("rst_ctrl", v, 32'h0000_0804);
    addr = 2'd2; #1;
    check("unselected_read", read_data, 32'h0);

    // DIV=1, LEN=8, 0xA5
    bus_write(2'd2, 32'h0000_0801);
    bus_write(2'd0, 32'h0000_00A5);
    run_xfer(200, bc, rs, bits, fcs);
    check("a5_cs_low", fcs, 1'b0);
    check("a5_busy_cycles", bc, 34);
    check("a5_rises", rs, 8);
    check("a5_mosi", bits, 32'hA5);
    bus_read(2'd1, v); check("a5_status", v, 32'h2);

    // LEN=0 means 32 bits, DIV=1, loopback receive
    bus_write(2'd2, 32'h0000_0001);
    bus_write(2'd0, 32'h8000_0001);
    run_xfer(400, bc, rs, bits, fcs);
    check("w32_rises", rs, 32);
    check("w32_mosi", bits, 32'h8000_0001);
    check("w32_busy_cycles", bc, 130);
    bus_read(2'd0, v);
`ifdef SPI_RX_EN
    check("w32_rx", v, 32'h8000_0001);
`else
    check("w32_rx_off", v, 32'h0);
`endif
    bus_write(2'd1, 32'h2);

    // Overrun and CTRL write while busy
    bus_write(2'd2, 32'h0000_0801);
    bus_write(2'd0, 32'h0000_003C);
    repeat (3) @(posedge clk);
    #1;
    bus_write(2'd0, 32'h0000_0055);
    bus_write(2'd2, 32'h0000_0003);
    bus_read(2'd1, v); check("ovr_status_busy", v, 32'h5);
    run_xfer(200, bc, rs, bits, fcs);
    bus_read(2'd2, v); check("ovr_ctrl_kept", v, 32'h0000_0801);
    bus_read(2'd1, v); check("ovr_status_done", v, 32'h6);
    bus_write(2'd1, 32'h6);
    bus_read(2'd1, v); check("status_cleared", v, 32'h0);

    // Interrupt enable, then a done clear landing on the set cycle
    bus_write(2'd2, 32'h0001_0801);
    bus_write(2'd0, 32'h0000_0096);
    run_xfer(200, bc, rs, bits, fcs);
    check("irq_after_done", irq, 1'b1);
    bus_write(2'd1, 32'h2);
    check("irq_cleared", irq, 1'b0);
    bus_write(2'd0, 32'h0000_005A);
    for (int i = 0; i < 200 && q.size() != 1; i++) begin
      @(posedge clk); #1;
    end
    check("reach_last_cycle", q.size(), 1);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, v); check("set_beats_clear", v, 32'h2);
    check("irq_set_wins", irq, 1'b1);
    bus_write(2'd1, 32'h6);

    // Reset during bit 3 high phase
    bus_write(2'd2, 32'h0000_0801);
    bus_write(2'd0, 32'h0000_00FF);
    repeat (14) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", spi_cs_n, 1'b1);
    check("midrst_sck", spi_clk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    bus_read(2'd2, v); check("midrst_ctrl", v, 32'h0000_0804);
    bus_write(2'd0, 32'h0000_00C3);
    run_xfer(300, bc, rs, bits, fcs);
    check("post_rst_busy_cycles", bc, 85);
    check("post_rst_rises", rs, 8);
    check("post_rst_mosi", bits, 32'hC3);

    // Randomized transfers
    for (int it = 0; it < 12; it++) begin
      dv = $urandom_range(0, 3);
      c  = ($urandom & 32'h0001_1F00) | dv;
      n  = (c[12:8] == 5'd0) ? 32 : int'(c[12:8]);
      d  = $urandom;
      ovr_try = ($urandom_range(0, 2) == 0);
      bus_write(2'd2, c);
      bus_write(2'd0, d);
      if (ovr_try) bus_write(2'd0, $urandom);
      run_xfer(400, bc, rs, bits, fcs);
      check("rnd_rises", rs, n);
      check("rnd_mosi", bits, mask_n(d, n));
      check("rnd_busy_cycles", bc, (2 * n + 1) * (dv + 1) - (ovr_try ? 1 : 0));
      bus_read(2'd1, v);
      bus_read(2'd0, v);
      bus_read(2'd2, v);
      bus_write(2'd1, $urandom & 32'h6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
